// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: arbiter FSM encoding, starvation-limit
// default and starve-counter width helper.
package dmem_arb_pkg;

  typedef enum logic {
    PIPE_PRI  = 1'b0,
    DMA_FORCE = 1'b1
  } arb_state_t;

  localparam int STARVE_LIMIT_DEF = 4;

  function automatic int starve_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

  localparam int STARVE_CNT_W =
    starve_cnt_w(STARVE_LIMIT_DEF);

endpackage

// File: rtl/dmem_arb_starve_guard.sv
// dmem_arb_starve_guard: counts consecutive denied DMA cycles.
// Ports: clk, reset, dma_req, dma_gnt in; force_next out
// (counter reaches STARVE_LIMIT at the coming edge).
module dmem_arb_starve_guard
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CW           = STARVE_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_next
);

  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  // Saturating count of denied cycles; any grant or a
  // dropped request restarts the wait from zero.
  always_comb begin
    cnt_d = '0;
    if (dma_req && !dma_gnt) begin
      cnt_d = (cnt == LIM) ? cnt : cnt + 1'b1;
    end
  end

  // Looking at the next value lets the forced grant land in
  // the same cycle the registered count reaches the limit.
  assign force_next = (cnt_d == LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the D-MEM port between the MEM
// stage (priority) and a DMA/debug requester.
// Ports: pipe_* (MEM stage, combinational load data),
// dma_* (held request, registered read data), mem_* (array).
// Define DMEM_ARB_FAIRNESS_EN for the starvation guard;
// otherwise the pipeline has strict priority.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int WORDBITS     = 2,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_req,
  input  logic             pipe_we,
  input  logic [DBITS-1:0] pipe_addr,
  input  logic [DBITS-1:0] pipe_wdata,
  output logic [DBITS-1:0] pipe_rdata,
  output logic             pipe_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [DBITS-1:0] dma_addr,
  input  logic [DBITS-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [DBITS-1:0] dma_rdata,
  output logic [DBITS-1:0] mem_addr,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata
);

  if (WORDBITS < 0 || WORDBITS >= DBITS
      || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("dmem_port_arbiter: bad parameters");
  end

  logic pipe_gnt;

`ifdef DMEM_ARB_FAIRNESS_EN

  arb_state_t state;
  logic       force_next;

  dmem_arb_starve_guard #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (starve_cnt_w(STARVE_LIMIT))
  ) u_guard (
    .clk        (clk),
    .reset      (reset),
    .dma_req    (dma_req),
    .dma_gnt    (dma_gnt),
    .force_next (force_next)
  );

  // Grants are held off entirely while reset is high.
  always_comb begin
    pipe_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        state == PIPE_PRI: begin
          pipe_gnt = pipe_req;
          dma_gnt  = dma_req && !pipe_req;
        end
        state == DMA_FORCE: begin
          dma_gnt  = dma_req;
          pipe_gnt = pipe_req && !dma_req;
        end
        default: ;
      endcase
    end
  end

  assign pipe_stall = pipe_req && dma_gnt;

  // A forced grant lasts one cycle; we only enter it when
  // the pipeline is the one doing the denying.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PIPE_PRI;
    end else begin
      unique case (state)
        PIPE_PRI:
          state <= (pipe_req && force_next)
                 ? DMA_FORCE : PIPE_PRI;
        DMA_FORCE: state <= PIPE_PRI;
        default:   state <= PIPE_PRI;
      endcase
    end
  end

`else

  // Strict priority: DMA only gets idle pipeline cycles.
  assign pipe_gnt   = !reset && pipe_req;
  assign dma_gnt    = !reset && dma_req && !pipe_req;
  assign pipe_stall = 1'b0;

`endif

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (1'b1)
      pipe_gnt: begin
        mem_addr  = pipe_addr;
        mem_we    = pipe_we;
        mem_wdata = pipe_wdata;
      end
      dma_gnt: begin
        mem_addr  = dma_addr;
        mem_we    = dma_we;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign pipe_rdata = pipe_gnt ? mem_rdata : '0;

  // DMA load data is captured at the grant edge and kept
  // until the next DMA load.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_gnt && !dma_we;
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vectors, scoreboard queues
// checked by a negedge monitor; array model lives here.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  localparam logic [31:0] A10 = 32'h10;
  localparam logic [31:0] A20 = 32'h20;
  localparam logic [31:0] VB  = 32'hDEADBEEF;
  localparam logic [31:0] V2  = 32'h12345678;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_req, pipe_we;
  logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic        pipe_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:63];

  typedef struct {
    bit          dg, st, we, rd_chk;
    logic [31:0] addr, prd, rd;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] val;
  } rexp_t;

  exp_t  q  [$];
  rexp_t rq [$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    was_rst = 1'b0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_req   (pipe_req),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_rdata (pipe_rdata),
    .pipe_stall (pipe_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, req);
    end
  endtask

  // Monitor: pops one expectation per driven cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("dma_gnt", 32'(dma_gnt), 32'(e.dg));
      chk("pipe_stall", 32'(pipe_stall), 32'(e.st));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_addr", mem_addr, e.addr);
      chk("pipe_rdata", pipe_rdata, e.prd);
      if (e.rd_chk) chk("dma_rdata_rst", dma_rdata, e.rd);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      rexp_t r;
      r = rq.pop_front();
      chk("dma_rvalid", 32'(dma_rvalid), 32'd1);
      chk("dma_rdata", dma_rdata, r.val);
    end else if (dma_rvalid === 1'b1) begin
      chk("dma_rvalid_extra", 32'd1, 32'd0);
    end
  end

  task automatic step(
    input bit rst, pr, pw,
    input logic [31:0] pa, pd,
    input bit dr, dw,
    input logic [31:0] da, dd,
    input bit e_dg, e_st, e_we,
    input logic [31:0] e_addr, e_prd, e_dmard);
    exp_t e;
    reset = rst;
    pipe_req = pr; pipe_we = pw;
    pipe_addr = pa; pipe_wdata = pd;
    dma_req = dr; dma_we = dw;
    dma_addr = da; dma_wdata = dd;
    e.dg = e_dg; e.st = e_st; e.we = e_we;
    e.addr = e_addr; e.prd = e_prd;
    e.rd_chk = was_rst && !rst;
    e.rd = '0;
    q.push_back(e);
    if (e_dg && !dw) rq.push_back('{cyc + 1, e_dmard});
    was_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 0);
  endtask

  // Pipe loads 0x10 (0xDEADBEEF), DMA reads 0x20
  // (0x12345678); forced means the DMA wins this cycle.
  task automatic cont(input bit rst, dr, forced);
    step(rst, 1, 0, A10, 0, dr, 0, A20, 0,
         forced, forced, 0,
         rst ? 32'h0 : (forced ? A20 : A10),
         (rst || forced) ? 32'h0 : VB, V2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b1;
    pipe_req = 0; pipe_we = 0;
    pipe_addr = 0; pipe_wdata = 0;
    dma_req = 0; dma_we = 0;
    dma_addr = 0; dma_wdata = 0;
    @(posedge clk);
    #1;

    // Reset gating: requests present, nothing granted.
    step(1, 1, 1, A10, VB, 1, 1, A20, V2,
         0, 0, 0, 0, 0, 0);
    // Pipe store; old word reads back as 0.
    step(0, 1, 1, A10, VB, 0, 0, 0, 0,
         0, 0, 1, A10, 0, 0);
    // Pipe load sees the store at once.
    step(0, 1, 0, A10, 0, 0, 0, 0, 0,
         0, 0, 0, A10, VB, 0);
    // DMA read on idle pipe.
    step(0, 0, 0, 0, 0, 1, 0, A10, 0,
         1, 0, 0, A10, 0, VB);
    // DMA write then pipe load of the same word.
    step(0, 0, 0, 0, 0, 1, 1, A20, V2,
         1, 0, 1, A20, 0, 0);
    step(0, 1, 0, A20, 0, 0, 0, 0, 0,
         0, 0, 0, A20, V2, 0);
    idle();

    // Held contention.
    for (int i = 0; i < (FAIR ? 10 : 100); i++)
      cont(0, 1, FAIR && (i == 4 || i == 9));
    idle();

    // Reset in the third contention cycle.
    for (int i = 0; i < 8; i++)
      cont(i == 2, 1, FAIR && i == 7);
    idle();

    // DMA drops in the would-be forced cycle.
    for (int i = 0; i < 10; i++)
      cont(0, i != 4, FAIR && i == 9);
    idle();
    idle();
    idle();

    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("q_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
